// File: rtl/counter_sw_rpt.sv
// rtl/counter_sw_rpt.sv - switch-driven bounded up/down counter with debounce, auto-repeat and acceleration
// Each switch channel: polarity fix, 2-flop sync, debounce, repeat FSM producing registered step pulses.
module counter_sw_rpt #(
   parameter int WIDTH_COUNTER   = 8,
   parameter int STEP            = 10,
   parameter int STEP_FAST       = 50,
   parameter int REPEAT_DELAY    = 20_000_000,
   parameter int REPEAT_RATE     = 5_000_000,
   parameter int FAST_AFTER      = 8,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int ACTIVE_LOW      = 1,
   parameter int SATURATE        = 1,
   parameter int MIN_VAL         = 0,
   parameter int MAX_VAL         = 2**WIDTH_COUNTER - 1,
   parameter int RESET_VAL       = 0
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     switch_up_i,
   input  logic                     switch_down_i,
   input  logic                     clear_i,
   output logic [WIDTH_COUNTER-1:0] counter_o,
   output logic                     at_min_o,
   output logic                     at_max_o
);

   localparam int T_MAX_A = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int T_MAX   = (T_MAX_A > DEBOUNCE_CYCLES) ? T_MAX_A : DEBOUNCE_CYCLES;
   localparam int TW      = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);
   localparam int RW      = $clog2(FAST_AFTER + 2);
   localparam int CW      = WIDTH_COUNTER + 2;

   localparam logic [TW-1:0] RD_LOAD = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RR_LOAD = TW'(REPEAT_RATE - 1);
   localparam logic [TW-1:0] DB_LAST = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RPT_SAT = RW'(FAST_AFTER + 1);
   localparam logic [RW-1:0] FAST_AT = RW'(FAST_AFTER);

   localparam logic signed [CW-1:0] MIN_W  = CW'(MIN_VAL);
   localparam logic signed [CW-1:0] MAX_W  = CW'(MAX_VAL);
   localparam logic signed [CW-1:0] STEP_W = CW'(STEP);
   localparam logic signed [CW-1:0] FAST_W = CW'(STEP_FAST);
   localparam logic signed [CW-1:0] ONE_W  = CW'(1);
   localparam logic [WIDTH_COUNTER-1:0] MIN_C   = WIDTH_COUNTER'(MIN_VAL);
   localparam logic [WIDTH_COUNTER-1:0] MAX_C   = WIDTH_COUNTER'(MAX_VAL);
   localparam logic [WIDTH_COUNTER-1:0] RESET_C = WIDTH_COUNTER'(RESET_VAL);

   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

   // Channel 0 = up, channel 1 = down; 1 means pressed after polarity correction.
   logic [1:0] raw;
   logic [1:0] step;
   logic [1:0] fast;

   assign raw = (ACTIVE_LOW != 0) ? ~{switch_down_i, switch_up_i} : {switch_down_i, switch_up_i};

   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic          sync1, sync2, deb, deb_d;
      logic          step_q, fast_q, emit, emit_fast;
      state_t        state, state_nx;
      logic [TW-1:0] timer, timer_nx;
      logic [RW-1:0] rpt, rpt_nx;

      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb_d <= 1'b0;
         end else begin
            sync1 <= raw[g];
            sync2 <= sync1;
            deb_d <= deb;
         end
      end

      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign deb = sync2;
      end else begin : g_deb
         logic [TW-1:0] db_cnt;
         logic          deb_q;

         // Count consecutive cycles of disagreement; any agreement restarts the count.
         always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
               db_cnt <= '0;
               deb_q  <= 1'b0;
            end else if (sync2 == deb_q) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
               db_cnt <= '0;
               deb_q  <= sync2;
            end else begin
               db_cnt <= db_cnt + TW'(1);
            end
         end
         assign deb = deb_q;
      end

      always_comb begin
         state_nx  = state;
         timer_nx  = timer;
         rpt_nx    = rpt;
         emit      = 1'b0;
         emit_fast = 1'b0;
         if (!deb) begin
            state_nx = ST_IDLE;
            timer_nx = '0;
            rpt_nx   = '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!deb_d) begin
                     emit     = 1'b1;
                     timer_nx = RD_LOAD;
                     state_nx = ST_DELAY;
                  end
               end
               ST_DELAY: begin
                  if (timer == '0) begin
                     emit      = 1'b1;
                     emit_fast = (FAST_AFTER == 0);
                     rpt_nx    = RW'(1);
                     timer_nx  = RR_LOAD;
                     state_nx  = ST_REPEAT;
                  end else begin
                     timer_nx = timer - TW'(1);
                  end
               end
               ST_REPEAT: begin
                  if (timer == '0) begin
                     emit      = 1'b1;
                     // rpt holds the previous repeat number, so this step is rpt+1.
                     emit_fast = (rpt >= FAST_AT);
                     timer_nx  = RR_LOAD;
                     if (rpt != RPT_SAT) begin
                        rpt_nx = rpt + RW'(1);
                     end
                  end else begin
                     timer_nx = timer - TW'(1);
                  end
               end
               default: state_nx = ST_IDLE;
            endcase
         end
      end

      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni) begin
            state  <= ST_IDLE;
            timer  <= '0;
            rpt    <= '0;
            step_q <= 1'b0;
            fast_q <= 1'b0;
         end else begin
            state  <= state_nx;
            timer  <= timer_nx;
            rpt    <= rpt_nx;
            step_q <= emit;
            fast_q <= emit_fast;
         end
      end

      assign step[g] = step_q;
      assign fast[g] = fast_q;
   end

   logic signed [CW-1:0]     cur, mag, res;
   logic [WIDTH_COUNTER-1:0] counter_nx;

   // Two extra bits keep sum and difference exact before the bound fold.
   always_comb begin
      cur        = signed'({2'b00, counter_o});
      mag        = (step[0] ? fast[0] : fast[1]) ? FAST_W : STEP_W;
      res        = cur;
      counter_nx = counter_o;
      if (step == 2'b01) begin
         res = cur + mag;
         if (res > MAX_W) begin
            res = (SATURATE != 0) ? MAX_W : MIN_W + (res - MAX_W - ONE_W);
         end
      end else if (step == 2'b10) begin
         res = cur - mag;
         if (res < MIN_W) begin
            res = (SATURATE != 0) ? MIN_W : MAX_W - (MIN_W - res - ONE_W);
         end
      end
      counter_nx = res[WIDTH_COUNTER-1:0];
      if (clear_i) begin
         counter_nx = RESET_C;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         counter_o <= RESET_C;
      end else begin
         counter_o <= counter_nx;
      end
   end

   assign at_min_o = (counter_o == MIN_C);
   assign at_max_o = (counter_o == MAX_C);

endmodule

// File: doc/counter_sw_rpt.md
Name: counter_sw_rpt

Overview:
- Parametrised next-generation switch-driven up/down counter for the board-level UI.
- Takes two raw mechanical switches and synchronises and debounces each one.
- Produces one step per press, then auto-repeat while held, then accelerated steps after sustained hold.
- Counter is bounded to [MIN_VAL, MAX_VAL], with selectable saturate or wrap. Drives display/setpoint logic.

Parameters:
WIDTH_COUNTER, 8, counter width in bits
STEP, 10, normal step magnitude
STEP_FAST, 50, step magnitude after acceleration; must be ≤ MAX_VAL-MIN_VAL+1
REPEAT_DELAY, 20_000_000, cycles from press step to first repeat step
REPEAT_RATE, 5_000_000, cycles between subsequent repeat steps
FAST_AFTER, 8, number of repeat steps at STEP before switching to STEP_FAST
DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required to accept a level change; 0 = bypass
ACTIVE_LOW, 1, 1 = switches pulled up (pressed = 0)
SATURATE, 1, 1 = clamp at bounds, 0 = wrap within [MIN_VAL, MAX_VAL]
MIN_VAL, 0, lower bound
MAX_VAL, 2**WIDTH_COUNTER-1, upper bound; MIN_VAL < MAX_VAL
RESET_VAL, 0, value after reset/clear; MIN_VAL ≤ RESET_VAL ≤ MAX_VAL

Ports:
clk_i  input  1  system clock
reset_ni  input  1  asynchronous active-low reset
switch_up_i  input  1  raw up switch, asynchronous
switch_down_i  input  1  raw down switch, asynchronous
clear_i  input  1  synchronous clear to RESET_VAL
counter_o  output  WIDTH_COUNTER  counter value
at_min_o  output  1  counter_o == MIN_VAL (combinational from register)
at_max_o  output  1  counter_o == MAX_VAL

Behaviour:
- Clocking and reset:
  - One clock: clk_i. Reset is asynchronous and active-low on reset_ni.
  - On reset: counter_o = RESET_VAL. Synchronisers, debounced levels, timers and FSMs are cleared to released/IDLE.
- Input conditioning, per channel:
  - Polarity inversion per ACTIVE_LOW, then a 2-flop synchroniser.
  - Debounce: the debounced level copies the synchronised level after it has differed for DEBOUNCE_CYCLES consecutive cycles. Any agreement in between restarts the count.
- Step pulse:
  - A step pulse is asserted one cycle on the debounced rising edge, and by the repeat FSM.
  - Latency: counter_o updates DEBOUNCE_CYCLES+3 cycles after the first clock edge that samples the new raw level.
- Repeat FSM, per channel, independent:
  - IDLE: on debounced rising edge → emit step, load timer, go to DELAY.
  - DELAY: after REPEAT_DELAY cycles → emit step, rpt_cnt=1, go to REPEAT.
  - REPEAT: every REPEAT_RATE cycles → emit step, rpt_cnt++ (saturating).
  - Debounced release in any state → IDLE; timers and rpt_cnt are cleared the same cycle.
- Step size:
  - Press step and repeat steps 1..FAST_AFTER use STEP.
  - Repeat steps after that use STEP_FAST.
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_RATE, DEBOUNCE_CYCLES)+1).
- Arithmetic is performed in WIDTH_COUNTER+2 signed bits, with no intermediate overflow.
  - Saturate mode: result is clamped to [MIN_VAL, MAX_VAL].
  - Wrap mode, sum > MAX_VAL: MIN_VAL + (sum-MAX_VAL-1).
  - Wrap mode, diff < MIN_VAL: MAX_VAL - (MIN_VAL-diff-1).
- Update priority:
  - clear_i highest; the FSMs keep running.
  - Up step and down step in the same cycle → no change.
  - Otherwise apply the single step.
- Both switches held: each FSM keeps running. The counter changes only on cycles where exactly one channel emits a step.

Test Plan (WIDTH 8, STEP 10, STEP_FAST 50, REPEAT_DELAY 20, REPEAT_RATE 5, FAST_AFTER 2, DEBOUNCE 4, ACTIVE_LOW 1, SATURATE 1, MIN 0, MAX 200, RESET_VAL 0):
1. Up switch low for 12 cycles, then high → counter_o 0→10 at DEBOUNCE+3 = 7 cycles, one step only. Release produces no step.
2. Up held 60 cycles → relative to press step: 10 (t0), 20 (t+20), 30 (t+25), 80 (t+30), 130 (t+35), 180 (t+40), 200 (t+45, clamped), then stays 200 with at_max_o=1.
3. Raw up toggling every 2 cycles for 16 cycles, then stable low → exactly one +10 step. No step during the bounce.
4. SATURATE=0: from 200, up press → 9. From 0, down press → 191. at_min_o=1 only at 0.
5. Both switches pressed on the same edge → counter unchanged. Release down at t+10 with up held → first up repeat at t+20 gives +10.
6. Up held in REPEAT, pulse clear_i → counter 0 next cycle and repeats continue from 0. Assert reset_ni mid-hold → counter 0 asynchronously. After release of reset, a new step needs a fresh debounced press.
